pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter STAGES, default 5: pipeline stage count; stage 0 is fetch and the stage index rises toward writeback.
REQ-002 SHALL have parameter ADDR_W, default 32: redirect PC width.
REQ-003 SHALL have parameter FLUSH_DEPTH, default 3: stages 0..FLUSH_DEPTH-1 are flushed on a redirect; legal range is 1..STAGES.
REQ-004 SHALL have parameter WDOG_LIMIT, default 255: stall-cycle count that raises timeout; legal range is 1..65535.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-007 SHALL have port rdy, input, 1 bit: global ready; 0 freezes the whole pipeline.
REQ-008 SHALL have port stall_req_i, input, STAGES bits: per-stage stall request.
REQ-009 SHALL have port set_pc_e_i, input, 1 bit: redirect request.
REQ-010 SHALL have port set_pc_i, input, ADDR_W bits: redirect target.
REQ-011 SHALL have port set_pc_e_o, output, 1 bit: redirect issued to fetch.
REQ-012 SHALL have port set_pc_o, output, ADDR_W bits: issued redirect target.
REQ-013 SHALL have port flush_o, output, STAGES bits: per-stage flush.
REQ-014 SHALL have port stall_o, output, STAGES bits: per-stage stall.
REQ-015 SHALL have port redir_pend_o, output, 1 bit: a redirect is held pending.
REQ-016 SHALL have port timeout_o, output, 1 bit: stall watchdog fired (sticky).
REQ-017 SHALL have port perf_sel_i, input, clog2(STAGES) bits: counter select.
REQ-018 SHALL have port perf_cnt_o, output, 32 bits: selected stall counter.

Function
REQ-019 SHALL drive stall_o all ones whenever rdy=0, regardless of other inputs.
REQ-020 SHALL, with rdy=1, set stall_o[k]=1 iff stall_req_i[j]=1 for some j>=k (combinational, zero latency); e.g. STAGES=5, stall_req_i[3] only -> 01111.
REQ-021 SHALL issue a redirect combinationally in the same cycle (set_pc_e_o=1, set_pc_o=set_pc_i) when set_pc_e_i=1, stall_o[0]=0 and no redirect is pending.
REQ-022 SHALL capture the request into a pending register (target plus valid) when set_pc_e_i=1 and stall_o[0]=1, asserting redir_pend_o from the next cycle.
REQ-023 SHALL make a new set_pc_e_i overwrite the pending target; the youngest redirect always wins.
REQ-024 SHALL, while pending and with stall_o[0]=0, issue the pending target from the register, clear pending at the edge, and ignore a simultaneous set_pc_e_i for issue only (it is captured as the new pending).
REQ-025 SHALL assert flush_o[k]=1 for k<FLUSH_DEPTH exactly in every cycle where set_pc_e_o=1, and keep all other bits 0.
REQ-026 SHALL run a watchdog of width clog2(WDOG_LIMIT+1): it increments each cycle with rdy=1 and any stall_req_i bit set, clears on a cycle with no request, and saturates at WDOG_LIMIT.
REQ-027 SHALL set timeout_o at the edge where the watchdog reaches WDOG_LIMIT and hold it until reset.
REQ-028 SHALL hold the pending register and the watchdog unchanged while rdy=0.

Reset
REQ-029 SHALL, on rst=0, immediately clear the pending valid and target, the watchdog, timeout_o, and all perf counters, independent of clk.
REQ-030 SHALL discard a pending redirect on reset mid-operation; no redirect is issued after release unless set_pc_e_i is asserted again.
REQ-031 SHALL, during reset, drive set_pc_e_o=0, flush_o=0 and redir_pend_o=0, and derive stall_o per REQ-019/020.

Configuration
REQ-032 SHALL, with macro PIPE_CTRL_PERF_EN defined, keep STAGES 32-bit wrapping counters; counter k increments each cycle with rdy=1 where k is the highest-index set bit of stall_req_i, and perf_cnt_o returns counter[perf_sel_i] combinationally (0 for out-of-range values).
REQ-033 SHALL, with PIPE_CTRL_PERF_EN undefined, implement no counters and tie perf_cnt_o to 0.

Verification
REQ-034 SHALL cover priority: defaults, stall_req_i=00010 -> stall_o=00011; 01010 -> 01111; rdy=0 -> 11111.
REQ-035 SHALL cover immediate redirect: set_pc_e_i=1, set_pc_i=0x0000_1000, no stall -> same cycle set_pc_e_o=1, set_pc_o=0x1000, flush_o=00111.
REQ-036 SHALL cover held redirect: stall_req_i=01000 with redirect to 0x2000, then 0x3000 one cycle later, stall released at cycle 4 -> redir_pend_o high for cycles 1-4, a single issue of 0x3000 in cycle 4 with flush_o=00111.
REQ-037 SHALL cover the watchdog: WDOG_LIMIT=4 with stall_req_i held nonzero -> timeout_o rises after the 4th stalled edge and stays high after the stall drops.
REQ-038 SHALL cover reset mid-pend: rst asserted low while redir_pend_o=1 -> pending cleared asynchronously, and after release no set_pc_e_o is issued.
REQ-039 SHALL cover counters (PIPE_CTRL_PERF_EN): 7 cycles of stall_req_i=00100 -> perf_sel_i=2 reads 7 and perf_sel_i=1 reads 0.

Source files
------------

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall priority, redirect issue/hold with flush, stall watchdog.
// Optional per-stage stall counters are enabled by defining PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
  parameter int STAGES      = 5,
  parameter int ADDR_W      = 32,
  parameter int FLUSH_DEPTH = 3,
  parameter int WDOG_LIMIT  = 255,
  localparam int SEL_W      = (STAGES > 1) ? $clog2(STAGES) : 1,
  localparam int WD_W       = $clog2(WDOG_LIMIT + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic [STAGES-1:0] stall_req_i,
  input  logic              set_pc_e_i,
  input  logic [ADDR_W-1:0] set_pc_i,
  output logic              set_pc_e_o,
  output logic [ADDR_W-1:0] set_pc_o,
  output logic [STAGES-1:0] flush_o,
  output logic [STAGES-1:0] stall_o,
  output logic              redir_pend_o,
  output logic              timeout_o,
  input  logic [SEL_W-1:0]  perf_sel_i,
  output logic [31:0]       perf_cnt_o
);

  logic              pend_vld_q, pend_vld_d;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
  logic [WD_W-1:0]   wdog_q, wdog_d;
  logic              timeout_q, timeout_d;
  logic [STAGES-1:0] stall_vec;
  logic              issue;
  logic [ADDR_W-1:0] issue_pc;
  logic              any_req;

  assign any_req = |stall_req_i;

  // A stall in stage j backs up every younger stage 0..j.
  always_comb begin
    // NOTE: every variable gets a default first, so no path leaves it unassigned (no latch).
    stall_vec = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      stall_vec[k] = stall_req_i[k] | ((k < STAGES - 1) ? stall_vec[k+1] : 1'b0);
    end
    if (!rdy) stall_vec = '1;
  end

  assign stall_o = stall_vec;

  // A held redirect is older than a fresh request, so it goes out first.
  always_comb begin
    issue    = 1'b0;
    issue_pc = set_pc_i;
    if (!stall_vec[0]) begin
      if (pend_vld_q) begin
        issue    = 1'b1;
        issue_pc = pend_pc_q;
      end else if (set_pc_e_i) begin
        issue = 1'b1;
      end
    end
  end

  assign set_pc_e_o   = issue & rst;
  assign set_pc_o     = issue_pc;
  assign redir_pend_o = pend_vld_q;
  assign timeout_o    = timeout_q;

  always_comb begin
    flush_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (k < FLUSH_DEPTH) flush_o[k] = set_pc_e_o;
    end
  end

  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_pc_d  = pend_pc_q;
    wdog_d     = wdog_q;
    if (rdy) begin
      // Any request that cannot go out this cycle becomes the (youngest) pending target.
      if (set_pc_e_i && (stall_vec[0] || pend_vld_q)) begin
        pend_vld_d = 1'b1;
        pend_pc_d  = set_pc_i;
      end else if (issue && pend_vld_q) begin
        pend_vld_d = 1'b0;
      end
      if (!any_req) begin
        wdog_d = '0;
      end else if (wdog_q != WD_W'(WDOG_LIMIT)) begin
        wdog_d = wdog_q + WD_W'(1);
      end
    end
    timeout_d = timeout_q | (wdog_d == WD_W'(WDOG_LIMIT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_vld_q <= 1'b0;
      pend_pc_q  <= '0;
      wdog_q     <= '0;
      timeout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge value of the others.
      pend_vld_q <= pend_vld_d;
      pend_pc_q  <= pend_pc_d;
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]      perf_cnt_q [STAGES];
  logic [31:0]      perf_cnt_d [STAGES];
  logic [SEL_W-1:0] hi_idx;

  // Each stalled cycle is charged to the oldest stage requesting the stall.
  always_comb begin
    hi_idx     = '0;
    perf_cnt_o = '0;
    for (int k = 0; k < STAGES; k++) begin
      if (stall_req_i[k]) hi_idx = SEL_W'(k);
    end
    for (int k = 0; k < STAGES; k++) begin
      perf_cnt_d[k] = perf_cnt_q[k];
      if (rdy && any_req && (hi_idx == SEL_W'(k))) perf_cnt_d[k] = perf_cnt_q[k] + 32'd1;
      if (perf_sel_i == SEL_W'(k)) perf_cnt_o = perf_cnt_q[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: this array is a bank of counters that must start at zero, so it is reset
      // explicitly; a plain data memory would normally be left unreset.
      for (int k = 0; k < STAGES; k++) perf_cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) perf_cnt_q[k] <= perf_cnt_d[k];
    end
  end
`else
  logic unused_perf_sel;

  assign unused_perf_sel = ^perf_sel_i;
  assign perf_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: directed vectors push expectations, a negedge monitor pops and compares.
module tb_pipe_ctrl;

`ifdef PIPE_CTRL_PERF_EN
  localparam bit PERF_BUILD = 1'b1;
`else
  localparam bit PERF_BUILD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic [4:0]  stall_req_i = '0;
  logic        set_pc_e_i = 1'b0;
  logic [31:0] set_pc_i = '0;
  logic [2:0]  perf_sel_i = '0;
  logic        set_pc_e_o;
  logic [31:0] set_pc_o;
  logic [4:0]  flush_o;
  logic [4:0]  stall_o;
  logic        redir_pend_o;
  logic        timeout_o;
  logic [31:0] perf_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    logic [4:0]  stall;
    logic        spe;
    logic [31:0] spc;
    logic [4:0]  flush;
    logic        pend;
    logic        tout;
    logic        chk_perf;
    logic [31:0] perf;
  } exp_t;

  exp_t exp_q[$];

  pipe_ctrl #(.STAGES(5), .ADDR_W(32), .FLUSH_DEPTH(3), .WDOG_LIMIT(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .rdy         (rdy),
    .stall_req_i (stall_req_i),
    .set_pc_e_i  (set_pc_e_i),
    .set_pc_i    (set_pc_i),
    .set_pc_e_o  (set_pc_e_o),
    .set_pc_o    (set_pc_o),
    .flush_o     (flush_o),
    .stall_o     (stall_o),
    .redir_pend_o(redir_pend_o),
    .timeout_o   (timeout_o),
    .perf_sel_i  (perf_sel_i),
    .perf_cnt_o  (perf_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, req);
    end
  endtask

  // Monitor: outputs are sampled mid-cycle, away from the rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check({e.name, ".stall"}, 32'(stall_o), 32'(e.stall));
        check({e.name, ".set_pc_e"}, 32'(set_pc_e_o), 32'(e.spe));
        if (e.spe) check({e.name, ".set_pc"}, set_pc_o, e.spc);
        check({e.name, ".flush"}, 32'(flush_o), 32'(e.flush));
        check({e.name, ".pend"}, 32'(redir_pend_o), 32'(e.pend));
        check({e.name, ".timeout"}, 32'(timeout_o), 32'(e.tout));
        if (e.chk_perf) check({e.name, ".perf"}, perf_cnt_o, e.perf);
      end
    end
  end

  task automatic vec(input string name, input logic r, input logic rd, input logic [4:0] req,
                     input logic spe, input logic [31:0] spc, input logic [2:0] sel,
                     input logic [4:0] x_stall, input logic x_spe, input logic [31:0] x_spc,
                     input logic [4:0] x_flush, input logic x_pend, input logic x_tout,
                     input logic chk_perf, input logic [31:0] x_perf);
    exp_t e;
    @(posedge clk);
    #1;
    rst         = r;
    rdy         = rd;
    stall_req_i = req;
    set_pc_e_i  = spe;
    set_pc_i    = spc;
    perf_sel_i  = sel;
    e = '{name, x_stall, x_spe, x_spc, x_flush, x_pend, x_tout, chk_perf, x_perf};
    exp_q.push_back(e);
  endtask

  localparam bit NP = !PERF_BUILD;

  initial begin
    //   name             rst rdy req      spe   spc           sel   stall    spe  spc           flush    pnd  to   chkp perf
    vec("reset_outputs",  0,  1,  5'b00010, 1, 32'h0000_0055, 3'd0, 5'b00011, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    vec("idle",           1,  1,  5'b00000, 0, 32'h0,        3'd0, 5'b00000, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    vec("prio_00010",     1,  1,  5'b00010, 0, 32'h0,        3'd1, 5'b00011, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    vec("prio_01010",     1,  1,  5'b01010, 0, 32'h0,        3'd3, 5'b01111, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    vec("rdy_low",        1,  0,  5'b00000, 0, 32'h0,        3'd0, 5'b11111, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    vec("imm_redirect",   1,  1,  5'b00000, 1, 32'h0000_1000, 3'd0, 5'b00000, 1, 32'h0000_1000, 5'b00111, 0, 0, NP, 32'd0);
    vec("after_imm",      1,  1,  5'b00000, 0, 32'h0,        3'd0, 5'b00000, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    // Held redirect; the same four stalled edges also trip the watchdog (limit 4).
    vec("hold_c0",        1,  1,  5'b01000, 1, 32'h0000_2000, 3'd2, 5'b01111, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    vec("hold_c1",        1,  1,  5'b01000, 1, 32'h0000_3000, 3'd3, 5'b01111, 0, 32'h0,        5'b00000, 1, 0, NP, 32'd0);
    vec("hold_c2",        1,  1,  5'b01000, 0, 32'h0,        3'd3, 5'b01111, 0, 32'h0,        5'b00000, 1, 0, NP, 32'd0);
    vec("hold_c3",        1,  1,  5'b01000, 0, 32'h0,        3'd3, 5'b01111, 0, 32'h0,        5'b00000, 1, 0, NP, 32'd0);
    vec("hold_c4_issue",  1,  1,  5'b00000, 0, 32'h0,        3'd0, 5'b00000, 1, 32'h0000_3000, 5'b00111, 1, 1, NP, 32'd0);
    vec("hold_c5",        1,  1,  5'b00000, 0, 32'h0,        3'd0, 5'b00000, 0, 32'h0,        5'b00000, 0, 1, NP, 32'd0);
    // Reset while a redirect is pending.
    vec("rpend_c0",       1,  1,  5'b00001, 1, 32'h0000_4000, 3'd0, 5'b00001, 0, 32'h0,        5'b00000, 0, 1, NP, 32'd0);
    vec("rpend_c1",       1,  1,  5'b00001, 0, 32'h0,        3'd0, 5'b00001, 0, 32'h0,        5'b00000, 1, 1, NP, 32'd0);
    vec("rpend_in_reset", 0,  1,  5'b00000, 0, 32'h0,        3'd0, 5'b00000, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    vec("rpend_released", 1,  1,  5'b00000, 0, 32'h0,        3'd0, 5'b00000, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    // Pending issue with a simultaneous new request that becomes the next pending.
    vec("simul_c0",       1,  1,  5'b00001, 1, 32'h0000_5000, 3'd0, 5'b00001, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    vec("simul_c1",       1,  1,  5'b00000, 1, 32'h0000_6000, 3'd0, 5'b00000, 1, 32'h0000_5000, 5'b00111, 1, 0, NP, 32'd0);
    vec("simul_c2",       1,  1,  5'b00000, 0, 32'h0,        3'd0, 5'b00000, 1, 32'h0000_6000, 5'b00111, 1, 0, NP, 32'd0);
    vec("simul_c3",       1,  1,  5'b00000, 0, 32'h0,        3'd0, 5'b00000, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    // A request made while rdy=0 must not be captured.
    vec("rdy0_req",       1,  0,  5'b00000, 1, 32'h0000_7000, 3'd0, 5'b11111, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);
    vec("rdy0_after",     1,  1,  5'b00000, 0, 32'h0,        3'd0, 5'b00000, 0, 32'h0,        5'b00000, 0, 0, NP, 32'd0);

`ifdef PIPE_CTRL_PERF_EN
    vec("perf_reset",     0,  1,  5'b00000, 0, 32'h0,        3'd2, 5'b00000, 0, 32'h0,        5'b00000, 0, 0, 1, 32'd0);
    for (int i = 0; i < 7; i++) begin
      vec($sformatf("perf_c%0d", i), 1, 1, 5'b00100, 0, 32'h0, 3'd2, 5'b00111, 0, 32'h0,
          5'b00000, 0, (i >= 4), 1, 32'(i));
    end
    vec("perf_sel2",      1,  1,  5'b00000, 0, 32'h0,        3'd2, 5'b00000, 0, 32'h0,        5'b00000, 0, 1, 1, 32'd7);
    vec("perf_sel1",      1,  1,  5'b00000, 0, 32'h0,        3'd1, 5'b00000, 0, 32'h0,        5'b00000, 0, 1, 1, 32'd0);
    vec("perf_sel7",      1,  1,  5'b00000, 0, 32'h0,        3'd7, 5'b00000, 0, 32'h0,        5'b00000, 0, 1, 1, 32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
